mux_scan: RTL and testbench
===========================

Name: mux_scan

Overview:
- Parametrised N-channel, W-bit multiplexer with a registered output.
- Two modes:
  - Manual: the channel comes from the select input `sl`.
  - Scan: an internal state machine steps round-robin through all channels, holding each channel for DWELL cycles.
- Sits in front of shared single-channel consumers, such as display or monitor logic that sweeps several data sources.
- Successor to the 2:1 combinational selector.

Parameters:
- W, 8, data width per channel (W>=1)
- N, 4, channel count (N>=2)
- SW, 2, select width; must satisfy 2**SW >= N
- DWELL, 4, cycles each channel is held in scan mode (DWELL>=1)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- din  in  N*W  packed channel data; channel k = din[k*W +: W]
- sl  in  SW  manual channel select
- mode  in  1  0 = manual, 1 = scan
- hold  in  1  scan mode only: freezes the dwell counter and the channel pointer
- out  out  W  registered selected data
- ch  out  SW  channel index of the current `out` value, aligned with `out`
- vld  out  1  `out`/`ch` carry a legal channel
- wrap  out  1  one-cycle pulse, aligned with `out`, on the first `out` cycle of channel 0 after the pointer wraps from N-1

Behaviour:
- State machine and internal registers:
  - States: MAN, SCAN.
  - Internal registers: `sel` (SW bits, scan pointer) and `cnt` (dwell counter, wide enough for DWELL-1).
- Reset (rst=1 at an edge):
  - Internal: state=MAN, sel=0, cnt=0.
  - Outputs: out=0, ch=0, vld=0, wrap=0.
  - Reset overrides every other input, including mid-scan.
- Selected channel c, combinational each cycle:
  - `sl` when state=MAN.
  - `sel` when state=SCAN.
- Output register, every non-reset edge:
  - If c<N: out<=din[c], ch<=c, vld<=1.
  - Else (manual only, sl>=N, possible only when N<2**SW): out and ch hold, vld<=0.
  - Latency: `din`/`sl` to `out` is 1 cycle.
- In MAN state:
  - mode=0: stay in MAN; sel and cnt untouched.
  - mode=1: next state SCAN; sel<=0, cnt<=0. Channel 0 reaches `out` 2 edges after mode rises.
  - `hold` is ignored.
- In SCAN state:
  - mode=0: next state MAN; cnt<=0. The current cycle still uses `sel`, so `sl` reaches `out` 2 edges after mode falls.
  - mode=1, hold=1: cnt and sel frozen; out keeps re-sampling din[sel], so live data still flows; wrap<=0.
  - mode=1, hold=0, cnt<DWELL-1: cnt<=cnt+1.
  - mode=1, hold=0, cnt==DWELL-1: cnt<=0; sel<=(sel==N-1)?0:sel+1.
- Dwell timing:
  - Each channel appears on `out` for exactly DWELL consecutive cycles absent hold.
  - DWELL=1 advances every cycle.
- wrap rules:
  - wrap<=1 on the same edge that `out` first takes channel 0 after a wrap from N-1; the pulse lasts 1 cycle.
  - Entry into SCAN, which starts at channel 0, does not assert wrap.
- Simultaneous events:
  - mode falling on the dwell-terminal cycle: state change takes priority; sel is not advanced and wrap stays 0.
  - hold with mode=0: no effect.
- The pointer never leaves 0..N-1, so vld=1 throughout SCAN.

Test Plan:
- Reset, then manual select. Stimulus: rst=1 for 2 cycles with din channels = {8'h44,8'h33,8'h22,8'h11} (ch3..ch0), then rst=0, mode=0, sl=2. Response: out=0/vld=0 during reset; out=8'h33, ch=2, vld=1 one edge after release. Changing sl to 0 gives out=8'h11 on the next edge.
- Scan sweep. Stimulus: DWELL=3, mode 0->1, hold=0. Response: from the 2nd edge, `out` shows 11,11,11,22,22,22,33,33,33,44,44,44,11; wrap=1 only on the first 11 after the 44s; entry into SCAN gives wrap=0.
- Hold. Stimulus: assert hold for 5 cycles while ch=1, changing din ch1 to 8'h5A mid-hold. Response: ch stays 1 for 5 extra cycles, out follows to 8'h5A one edge later, then dwell resumes with the remaining count.
- Mode exit on the terminal dwell cycle. Stimulus: mode falls when cnt==DWELL-1 and sel==N-1, with sl=1. Response: no advance and no wrap pulse; ch=1 appears 2 edges after the fall.
- Reset mid-scan. Stimulus: rst=1 for 1 cycle while ch=2. Response: next edge out=0, ch=0, vld=0, wrap=0, state MAN; with mode still 1, scan restarts at channel 0.
- Illegal select (N=3, SW=2). Stimulus: sl=3 in manual. Response: vld=0, out/ch hold their previous values; a legal sl restores vld=1 next edge.

Source files
------------

// File: rtl/mux_scan.sv
// mux_scan: N-channel, W-bit multiplexer with a registered output.
// In manual mode the channel follows sl. In scan mode an internal pointer
// steps round-robin through every channel and holds each one for DWELL cycles.
// The ch output tags every out value with its source channel. The wrap output
// marks the first channel-0 sample after the pointer rolls over from N-1.
module mux_scan #(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int SW    = 2,
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  din,
    input  logic [SW-1:0]   sl,
    input  logic            mode,
    input  logic            hold,
    output logic [W-1:0]    out,
    output logic [SW-1:0]   ch,
    output logic            vld,
    output logic            wrap
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [SW-1:0] SEL_LAST = SW'(N - 1);

    localparam logic [0:0] MAN  = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrapPend_q, wrapPend_d;
    logic          wrap_d;

    logic [W-1:0]  out_q;
    logic [SW-1:0] ch_q;
    logic          vld_q;
    logic          wrap_q;

    logic [SW-1:0] chSel;
    logic          chLegal;
    logic [W-1:0]  chData;

    // Pick the active channel and fetch its data. Codes at or above N are illegal.
    always_comb begin
        chSel   = (state_q == SCAN) ? sel_q : sl;
        chLegal = (int'(chSel) < N);
        chData  = '0;
        for (int k = 0; k < N; k++) begin
            if (chSel == SW'(k)) begin
                chData = din[k*W +: W];
            end
        end
    end

    // Mode transitions, dwell counting and pointer advance.
    // wrapPend marks a rollover one cycle early, so wrap lines up with channel 0 on out.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        wrapPend_d = 1'b0;
        wrap_d     = wrapPend_q && !(mode && hold);
        if (state_q == MAN) begin
            if (mode) begin
                state_d = SCAN;
                sel_d   = '0;
                cnt_d   = '0;
            end
        end else begin
            if (!mode) begin
                state_d = MAN;
                cnt_d   = '0;
            end else if (!hold) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (sel_q == SEL_LAST) begin
                        sel_d      = '0;
                        wrapPend_d = 1'b1;
                    end else begin
                        sel_d = sel_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // Scan control registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MAN;
            sel_q      <= '0;
            cnt_q      <= '0;
            wrapPend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            wrapPend_q <= wrapPend_d;
        end
    end

    // Output register. An illegal select keeps the last out/ch and only drops vld.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            ch_q   <= '0;
            vld_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            if (chLegal) begin
                out_q <= chData;
                ch_q  <= chSel;
                vld_q <= 1'b1;
            end else begin
                vld_q <= 1'b0;
            end
            wrap_q <= wrap_d;
        end
    end

    assign out  = out_q;
    assign ch   = ch_q;
    assign vld  = vld_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan: checks two configurations of mux_scan.
// Instance A uses N=4 and DWELL=3. Instance B uses N=3 and DWELL=1, so it has an
// illegal select code and advances every cycle. Both share clk and rst.
module tb_mux_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [31:0] dinA = '0;
    logic [1:0]  slA = '0;
    logic        modeA = 1'b0;
    logic        holdA = 1'b0;
    logic [7:0]  outA;
    logic [1:0]  chA;
    logic        vldA;
    logic        wrapA;

    logic [23:0] dinB = '0;
    logic [1:0]  slB = '0;
    logic        modeB = 1'b0;
    logic        holdB = 1'b0;
    logic [7:0]  outB;
    logic [1:0]  chB;
    logic        vldB;
    logic        wrapB;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] BASE = 32'h44332211;

    mux_scan #(.W(8), .N(4), .SW(2), .DWELL(3)) dutA (
        .clk(clk), .rst(rst), .din(dinA), .sl(slA), .mode(modeA), .hold(holdA),
        .out(outA), .ch(chA), .vld(vldA), .wrap(wrapA)
    );

    mux_scan #(.W(8), .N(3), .SW(2), .DWELL(1)) dutB (
        .clk(clk), .rst(rst), .din(dinB), .sl(slB), .mode(modeB), .hold(holdB),
        .out(outB), .ch(chB), .vld(vldB), .wrap(wrapB)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       m;
        logic       h;
        logic [1:0] s;
        logic [7:0] eOut;
        logic [1:0] eCh;
        logic       eVld;
        logic       eWrap;
    } vec_t;

    // Behavioural state of one multiplexer, kept as plain integers.
    typedef struct {
        bit         scan;
        int         ptr;
        int         cnt;
        bit         pend;
        logic [7:0] out;
        int         ch;
        bit         vld;
        bit         wrap;
    } model_t;

    vec_t   vecs[19];
    model_t mA;
    model_t mB;

    // Advance the model by one clock edge, given the inputs seen before that edge.
    function automatic model_t modelStep(model_t s, int n, int dwell, bit r, bit m, bit h,
                                         int sl, logic [31:0] d);
        model_t t;
        int     c;
        t = s;
        if (r) begin
            t.scan = 0; t.ptr = 0; t.cnt = 0; t.pend = 0;
            t.out = 8'h00; t.ch = 0; t.vld = 0; t.wrap = 0;
            return t;
        end
        c = s.scan ? s.ptr : sl;
        if (c < n) begin
            t.out = d[8*c +: 8];
            t.ch  = c;
            t.vld = 1;
        end else begin
            t.vld = 0;
        end
        t.wrap = s.pend && !(m && h);
        t.pend = 0;
        if (!s.scan) begin
            if (m) begin
                t.scan = 1; t.ptr = 0; t.cnt = 0;
            end
        end else if (!m) begin
            t.scan = 0; t.cnt = 0;
        end else if (!h) begin
            if (s.cnt == dwell - 1) begin
                t.cnt = 0;
                if (s.ptr == n - 1) begin
                    t.ptr = 0; t.pend = 1;
                end else begin
                    t.ptr = s.ptr + 1;
                end
            end else begin
                t.cnt = s.cnt + 1;
            end
        end
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] gOut, input logic [1:0] gCh,
                               input logic gVld, input logic gWrap, input logic [7:0] eOut,
                               input logic [1:0] eCh, input logic eVld, input logic eWrap);
        tests++;
        if (gOut !== eOut || gCh !== eCh || gVld !== eVld || gWrap !== eWrap) begin
            fails++;
            $display("[TB] FAIL %s: got out=%h ch=%0d vld=%b wrap=%b, expected out=%h ch=%0d vld=%b wrap=%b",
                     name, gOut, gCh, gVld, gWrap, eOut, eCh, eVld, eWrap);
        end
    endtask

    // Drive instance A and the shared reset, then wait until just after the edge.
    task automatic applyStimulus(input logic r, input logic m, input logic h, input logic [1:0] s,
                                 input logic [31:0] d);
        rst   = r;
        modeA = m;
        holdA = h;
        slA   = s;
        dinA  = d;
        @(posedge clk);
        #1;
    endtask

    // Drive instance B and the shared reset, then wait until just after the edge.
    task automatic stepB(input logic r, input logic m, input logic h, input logic [1:0] s,
                         input logic [23:0] d);
        rst   = r;
        modeB = m;
        holdB = h;
        slB   = s;
        dinB  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Table: reset, manual select, then a full scan sweep with a wrap.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 2'd2, 8'h00, 2'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 2'd2, 8'h00, 2'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 2'd2, 8'h33, 2'd2, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h11, 2'd0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 2'd3, 8'h44, 2'd3, 1'b1, 1'b0};
        for (int i = 5; i <= 16; i++) begin
            int k;
            k = (i - 5) / 3;
            vecs[i] = '{1'b0, 1'b1, 1'b0, 2'd3, 8'(8'h11 * (k + 1)), 2'(k), 1'b1, 1'b0};
        end
        vecs[17] = '{1'b0, 1'b1, 1'b0, 2'd3, 8'h11, 2'd0, 1'b1, 1'b1};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 2'd3, 8'h11, 2'd0, 1'b1, 1'b0};

        @(negedge clk);
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].r, vecs[i].m, vecs[i].h, vecs[i].s, BASE);
            checkOutput($sformatf("table[%0d]", i), outA, chA, vldA, wrapA,
                        vecs[i].eOut, vecs[i].eCh, vecs[i].eVld, vecs[i].eWrap);
        end

        // Hold while channel 1 is shown, with a data change during the hold.
        applyStimulus(1, 0, 0, 0, BASE);
        for (int e = 1; e <= 5; e++) applyStimulus(0, 1, 0, 0, BASE);
        checkOutput("holdStart", outA, chA, vldA, wrapA, 8'h22, 2'd1, 1, 0);
        for (int e = 6; e <= 7; e++) applyStimulus(0, 1, 1, 0, BASE);
        checkOutput("holdEarly", outA, chA, vldA, wrapA, 8'h22, 2'd1, 1, 0);
        applyStimulus(0, 1, 1, 0, 32'h44335A11);
        checkOutput("holdLive", outA, chA, vldA, wrapA, 8'h5A, 2'd1, 1, 0);
        for (int e = 9; e <= 10; e++) applyStimulus(0, 1, 1, 0, 32'h44335A11);
        checkOutput("holdEnd", outA, chA, vldA, wrapA, 8'h5A, 2'd1, 1, 0);
        for (int e = 11; e <= 12; e++) applyStimulus(0, 1, 0, 0, 32'h44335A11);
        checkOutput("holdResume", outA, chA, vldA, wrapA, 8'h5A, 2'd1, 1, 0);
        applyStimulus(0, 1, 0, 0, 32'h44335A11);
        checkOutput("holdAdvance", outA, chA, vldA, wrapA, 8'h33, 2'd2, 1, 0);

        // mode falls on the last dwell cycle of channel N-1.
        applyStimulus(1, 0, 0, 1, BASE);
        for (int e = 1; e <= 12; e++) applyStimulus(0, 1, 0, 1, BASE);
        checkOutput("exitPre", outA, chA, vldA, wrapA, 8'h44, 2'd3, 1, 0);
        applyStimulus(0, 0, 0, 1, BASE);
        checkOutput("exitTerminal", outA, chA, vldA, wrapA, 8'h44, 2'd3, 1, 0);
        applyStimulus(0, 0, 0, 1, BASE);
        checkOutput("exitManual", outA, chA, vldA, wrapA, 8'h22, 2'd1, 1, 0);

        // Reset in the middle of a scan.
        applyStimulus(1, 0, 0, 3, BASE);
        for (int e = 1; e <= 8; e++) applyStimulus(0, 1, 0, 3, BASE);
        checkOutput("midScanCh2", outA, chA, vldA, wrapA, 8'h33, 2'd2, 1, 0);
        applyStimulus(1, 1, 0, 3, BASE);
        checkOutput("midScanReset", outA, chA, vldA, wrapA, 8'h00, 2'd0, 0, 0);
        applyStimulus(0, 1, 0, 3, BASE);
        checkOutput("restartEntry", outA, chA, vldA, wrapA, 8'h44, 2'd3, 1, 0);
        applyStimulus(0, 1, 0, 3, BASE);
        checkOutput("restartCh0", outA, chA, vldA, wrapA, 8'h11, 2'd0, 1, 0);

        // Instance B: illegal select, then single-cycle dwell with a wrap.
        stepB(1, 0, 0, 1, 24'hCCBBAA);
        stepB(0, 0, 0, 1, 24'hCCBBAA);
        checkOutput("bLegal", outB, chB, vldB, wrapB, 8'hBB, 2'd1, 1, 0);
        stepB(0, 0, 0, 3, 24'hCCBBAA);
        checkOutput("bIllegal", outB, chB, vldB, wrapB, 8'hBB, 2'd1, 0, 0);
        stepB(0, 0, 0, 3, 24'h112233);
        checkOutput("bIllegalHold", outB, chB, vldB, wrapB, 8'hBB, 2'd1, 0, 0);
        stepB(0, 0, 0, 2, 24'hCCBBAA);
        checkOutput("bRestore", outB, chB, vldB, wrapB, 8'hCC, 2'd2, 1, 0);
        stepB(0, 1, 0, 2, 24'hCCBBAA);
        checkOutput("bScanEntry", outB, chB, vldB, wrapB, 8'hCC, 2'd2, 1, 0);
        stepB(0, 1, 0, 2, 24'hCCBBAA);
        checkOutput("bScan0", outB, chB, vldB, wrapB, 8'hAA, 2'd0, 1, 0);
        stepB(0, 1, 0, 2, 24'hCCBBAA);
        checkOutput("bScan1", outB, chB, vldB, wrapB, 8'hBB, 2'd1, 1, 0);
        stepB(0, 1, 0, 2, 24'hCCBBAA);
        checkOutput("bScan2", outB, chB, vldB, wrapB, 8'hCC, 2'd2, 1, 0);
        stepB(0, 1, 0, 2, 24'hCCBBAA);
        checkOutput("bWrap", outB, chB, vldB, wrapB, 8'hAA, 2'd0, 1, 1);
        stepB(0, 1, 0, 2, 24'hCCBBAA);
        checkOutput("bAfterWrap", outB, chB, vldB, wrapB, 8'hBB, 2'd1, 1, 0);

        // Random traffic on both instances against the behavioural model.
        mA = '{0, 0, 0, 0, 8'h00, 0, 0, 0};
        mB = '{0, 0, 0, 0, 8'h00, 0, 0, 0};
        for (int i = 0; i < 600; i++) begin
            rst   = (i == 0) || ($urandom_range(0, 63) == 0);
            modeA = ($urandom_range(0, 15) == 0) ? ~modeA : modeA;
            modeB = ($urandom_range(0, 15) == 0) ? ~modeB : modeB;
            holdA = ($urandom_range(0, 3) == 0);
            holdB = ($urandom_range(0, 3) == 0);
            slA   = 2'($urandom_range(0, 3));
            slB   = 2'($urandom_range(0, 3));
            dinA  = $urandom;
            dinB  = 24'($urandom);
            mA = modelStep(mA, 4, 3, rst, modeA, holdA, int'(slA), dinA);
            mB = modelStep(mB, 3, 1, rst, modeB, holdB, int'(slB), {8'h00, dinB});
            @(posedge clk);
            #1;
            checkOutput($sformatf("randA[%0d]", i), outA, chA, vldA, wrapA,
                        mA.out, 2'(mA.ch), mA.vld, mA.wrap);
            checkOutput($sformatf("randB[%0d]", i), outB, chB, vldB, wrapB,
                        mB.out, 2'(mB.ch), mB.vld, mB.wrap);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
